// File: rtl/compare_pkg.sv
// Shared types and elaboration helpers for the chunk-serial magnitude comparator.
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk compare still needs a one-bit counter to keep the ports sane.
    function automatic int idx_width(input int nchunk);
        return ($clog2(nchunk) < 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/compare_chunk.sv
// Combinational CHUNK-bit unsigned compare: equality and greater-than of x against z.
module compare_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] z,
    output logic             eq,
    output logic             gt
);

    assign eq = (x == z);
    assign gt = (x > z);

endmodule

// File: rtl/compare_seq_nb.sv
// Chunk-serial magnitude comparator: walks both operands MSB chunk first and stops
// at the first differing chunk, reporting equal / greater / less with a done pulse.
module compare_seq_nb
    import compare_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CHUNK  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             y,
    output logic             gt,
    output logic             lt
);

    localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
    localparam int IDX_W  = idx_width(NCHUNK);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $fatal(1, "compare_seq_nb: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_sh_reg, a_sh_next;
    logic [WIDTH-1:0]   b_sh_reg, b_sh_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               y_reg, y_next;
    logic               gt_reg, gt_next;
    logic               lt_reg, lt_next;
    logic               chunk_eq;
    logic               chunk_gt;

    compare_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x  (a_sh_reg[WIDTH-1 -: CHUNK]),
        .z  (b_sh_reg[WIDTH-1 -: CHUNK]),
        .eq (chunk_eq),
        .gt (chunk_gt)
    );

    always_comb begin
        state_next = state_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        idx_next   = idx_reg;
        y_next     = y_reg;
        gt_next    = gt_reg;
        lt_next    = lt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_sh_next = a;
                    b_sh_next = b;
                    // Offset binary: flipping the sign bit makes two's-complement order unsigned.
                    if (SIGNED != 0) begin
                        a_sh_next[WIDTH-1] = ~a[WIDTH-1];
                        b_sh_next[WIDTH-1] = ~b[WIDTH-1];
                    end
                    idx_next   = '0;
                    y_next     = 1'b0;
                    gt_next    = 1'b0;
                    lt_next    = 1'b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!chunk_eq) begin
                    gt_next    = chunk_gt;
                    lt_next    = ~chunk_gt;
                    state_next = DONE;
                end else if (idx_reg == IDX_W'(NCHUNK - 1)) begin
                    y_next     = 1'b1;
                    state_next = DONE;
                end else begin
                    a_sh_next = a_sh_reg << CHUNK;
                    b_sh_next = b_sh_reg << CHUNK;
                    idx_next  = idx_reg + IDX_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            idx_reg   <= '0;
            y_reg     <= 1'b0;
            gt_reg    <= 1'b0;
            lt_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            idx_reg   <= idx_next;
            y_reg     <= y_next;
            gt_reg    <= gt_next;
            lt_reg    <= lt_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign y    = y_reg;
    assign gt   = gt_reg;
    assign lt   = lt_reg;

endmodule

// File: tb/tb_compare_seq_nb.sv
// Scoreboard bench for compare_seq_nb: unsigned 32/8, signed 32/8 and single-chunk 8/8 instances.
module tb_compare_seq_nb;

    typedef struct {
        logic [2:0] res;   // {y, gt, lt}
        int         n;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [2:0]  busy_v, done_v, y_v, gt_v, lt_v;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    compare_seq_nb #(.WIDTH(32), .CHUNK(8), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .y(y_v[0]), .gt(gt_v[0]), .lt(lt_v[0])
    );

    compare_seq_nb #(.WIDTH(32), .CHUNK(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .y(y_v[1]), .gt(gt_v[1]), .lt(lt_v[1])
    );

    compare_seq_nb #(.WIDTH(8), .CHUNK(8), .SIGNED(0)) u_dut_8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]),
        .busy(busy_v[2]), .done(done_v[2]), .y(y_v[2]), .gt(gt_v[2]), .lt(lt_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] res_of(input int sel);
        return {y_v[sel], gt_v[sel], lt_v[sel]};
    endfunction

    // Reference: arithmetic compare for the result, byte scan from the top for the latency.
    function automatic exp_t model(input int sel, input logic [31:0] av_in, input logic [31:0] bv_in);
        exp_t        e;
        int          w;
        logic [31:0] av, bv;
        logic        found;
        w  = (sel == 2) ? 8 : 32;
        av = (w == 8) ? (av_in & 32'hFF) : av_in;
        bv = (w == 8) ? (bv_in & 32'hFF) : bv_in;
        if (av == bv)
            e.res = 3'b100;
        else if ((sel == 1) ? ($signed(av) > $signed(bv)) : (av > bv))
            e.res = 3'b010;
        else
            e.res = 3'b001;
        e.n   = w / 8;
        found = 1'b0;
        for (int i = 0; i < w / 8; i++) begin
            if (!found && (((av >> (w - 8 * (i + 1))) & 32'hFF) != ((bv >> (w - 8 * (i + 1))) & 32'hFF))) begin
                e.n   = i + 1;
                found = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic do_compare(input int sel, input logic [31:0] av, input logic [31:0] bv,
                              input bit interfere, input string tag);
        exp_t e;
        int   cycles;
        bit   got_done;
        logic [2:0] res_done;
        @(negedge clk);
        a_v[sel]     = av;
        b_v[sel]     = bv;
        start_v[sel] = 1'b1;
        sb_q.push_back(model(sel, av, bv));
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        a_v[sel]     = $urandom;
        b_v[sel]     = $urandom;
        check_val({tag, "_busy_run"}, 32'(busy_v[sel]), 32'd1);
        check_val({tag, "_res_cleared"}, 32'(res_of(sel)), 32'd0);
        cycles   = 0;
        got_done = 1'b0;
        while (!got_done && cycles < 40) begin
            if (interfere && cycles == 0) begin
                start_v[sel] = 1'b1;
                a_v[sel]     = 32'h0;
                b_v[sel]     = 32'hFFFF_FFFF;
            end else begin
                start_v[sel] = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (done_v[sel]) got_done = 1'b1;
        end
        start_v[sel] = 1'b0;
        check_val({tag, "_done_seen"}, 32'(got_done), 32'd1);
        res_done = res_of(sel);
        if (got_done) begin
            if (sb_q.size() == 0) begin
                check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_val({tag, "_latency"}, 32'(cycles), 32'(e.n));
                check_val({tag, "_result"}, 32'(res_done), 32'(e.res));
                @(posedge clk);
                #1;
                check_val({tag, "_done_pulse"}, 32'(done_v[sel]), 32'd0);
                check_val({tag, "_busy_idle"}, 32'(busy_v[sel]), 32'd0);
                check_val({tag, "_res_hold"}, 32'(res_of(sel)), 32'(e.res));
            end
        end
        $display("cmp %-10s dut=%0d a=%08h b=%08h res(y,gt,lt)=%03b cycles=%0d", tag, sel, av, bv, res_done, cycles);
    endtask

    initial begin
        int   done_count;
        int   mode;
        logic [31:0] ra, rb;
        n_checks = 0;
        n_fail   = 0;

        // Reset held for two edges with start asserted on every instance.
        rst_n   = 1'b0;
        start_v = 3'b111;
        for (int k = 0; k < 3; k++) begin
            a_v[k] = $urandom;
            b_v[k] = $urandom;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++)
                check_val($sformatf("reset_outs%0d", k),
                          32'({busy_v[k], done_v[k], y_v[k], gt_v[k], lt_v[k]}), 32'd0);
        end
        rst_n   = 1'b1;
        start_v = 3'b000;

        do_compare(0, 32'h0000_000F, 32'h0000_000F, 1'b0, "equal");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_val("equal_hold", 32'(res_of(0)), 32'b100);
        end

        do_compare(0, 32'hFF00_0000, 32'h0000_0000, 1'b0, "early_gt");
        do_compare(0, 32'h0000_0000, 32'hFF00_0000, 1'b0, "early_lt");
        do_compare(0, 32'h0000_000F, 32'h0000_000E, 1'b1, "late_gt");

        do_compare(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "signed_lt");
        do_compare(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "unsign_gt");
        do_compare(1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, "signed_min");
        do_compare(1, 32'hFFFF_FF00, 32'hFFFF_FF01, 1'b0, "signed_lsb");

        // Reset in the second RUN cycle of an equal-operand compare.
        @(negedge clk);
        a_v[0]     = 32'h1234_5678;
        b_v[0]     = 32'h1234_5678;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("midrst_outs", 32'({busy_v[0], done_v[0], y_v[0], gt_v[0], lt_v[0]}), 32'd0);
        done_count = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done_v[0]) done_count++;
        end
        check_val("midrst_no_done", 32'(done_count), 32'd0);
        $display("cmp %-10s dut=0 a=12345678 b=12345678 aborted by reset", "midrst");
        do_compare(0, 32'h1234_5678, 32'h1234_5678, 1'b0, "after_rst");

        do_compare(2, 32'h0000_000F, 32'h0000_000F, 1'b0, "w8_equal");
        do_compare(2, 32'h0000_0010, 32'h0000_000F, 1'b0, "w8_gt");

        for (int i = 0; i < 12; i++) begin
            ra   = $urandom;
            mode = $urandom_range(0, 2);
            case (mode)
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = $urandom;
            endcase
            do_compare(i % 2, ra, rb, 1'b0, $sformatf("rand%0d", i));
        end

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
